// File: rtl/collectible_pkg.sv
// Shared types and constants for the collectible spawner slice.
package collectible_pkg;

    localparam int TYPE_W = 2;
    localparam logic [TYPE_W-1:0] TYPE_NONE = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_CAPTURE = 2'd2
    } spawn_state_t;

    // A slot or generator value holds a real collectible when it is not TYPE_NONE.
    function automatic logic is_occupied(input logic [TYPE_W-1:0] t);
        return (t != TYPE_NONE);
    endfunction

endpackage

// File: rtl/collectible_slot.sv
// One collectible slot: stored type plus its respawn countdown.
module collectible_slot
    import collectible_pkg::*;
#(
    parameter int RESPAWN_TICKS = 60,
    parameter int TIMER_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [TYPE_W-1:0] i_load_type,
    input  logic              i_clear,
    input  logic              i_tick,
    output logic [TYPE_W-1:0] o_type,
    output logic              o_ready
);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESPAWN_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);

    logic [TYPE_W-1:0]  r_type;
    logic [TIMER_W-1:0] r_timer;

    // Slot state: a pickup restarts the respawn wait (and beats a same-cycle tick),
    // a spawn fills the slot, and ticks drain an empty slot's timer down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_type  <= TYPE_NONE;
            r_timer <= TIMER_ZERO;
        end else if (i_clear) begin
            r_type  <= TYPE_NONE;
            r_timer <= TIMER_LOAD;
        end else if (i_load) begin
            r_type  <= i_load_type;
            r_timer <= TIMER_ZERO;
        end else if (i_tick && !is_occupied(r_type) && (r_timer != TIMER_ZERO)) begin
            r_timer <= r_timer - TIMER_ONE;
        end else begin
            r_timer <= r_timer;
        end
    end

    assign o_type  = r_type;
    assign o_ready = !is_occupied(r_type) && (r_timer == TIMER_ZERO);

endmodule

// File: rtl/collectible_spawner.sv
// Collectible spawner: requests random types for empty, expired slots and
// retires collectibles on player pickup, reporting the collected type.
module collectible_spawner
    import collectible_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int RESPAWN_TICKS = 60,
    parameter int TIMER_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spawn_en,
    input  logic                          tick,
    output logic                          rand_en,
    input  logic [TYPE_W-1:0]             rand_type,
    input  logic                          pickup_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0]  pickup_slot,
    output logic [TYPE_W*NUM_SLOTS-1:0]   slot_types,
    output logic                          collected_vld,
    output logic [TYPE_W-1:0]             collected_type
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    spawn_state_t      r_state;
    logic [IDX_W-1:0]  r_tgt;
    logic              r_rand_en;
    logic              r_collected_vld;
    logic [TYPE_W-1:0] r_collected_type;

    logic [TYPE_W-1:0]    w_type [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_ready;
    logic [NUM_SLOTS-1:0] w_clear;
    logic [NUM_SLOTS-1:0] w_load;
    logic                 w_tick_en;
    logic                 w_any_ready;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [TYPE_W-1:0]    w_pick_type;
    logic                 w_pick_hit;

    // Timers only advance while the game is running.
    assign w_tick_en = tick && spawn_en;

    // Pickup decode: an index with no matching slot reads as empty, so
    // out-of-range indices and empty slots are ignored the same way.
    always_comb begin
        w_pick_type = TYPE_NONE;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_pick_type = (pickup_slot == IDX_W'(i)) ? w_type[i] : w_pick_type;
        end
        w_pick_hit = pickup_valid && is_occupied(w_pick_type);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_clear[i] = w_pick_hit && (pickup_slot == IDX_W'(i));
        end
    end

    // Lowest-index ready slot; scanning downward lets the lowest match win.
    always_comb begin
        w_pick_idx  = {IDX_W{1'b0}};
        w_any_ready = |w_ready;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_pick_idx = w_ready[i] ? IDX_W'(i) : w_pick_idx;
        end
    end

    // Spawn write: only a nonzero generator value ever lands in the target slot.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_load[i] = (r_state == ST_CAPTURE) && is_occupied(rand_type)
                        && (r_tgt == IDX_W'(i));
        end
    end

    // Spawn FSM: one request in flight; rand_en is high exactly while in REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tgt     <= {IDX_W{1'b0}};
            r_rand_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (spawn_en && w_any_ready) begin
                        r_tgt     <= w_pick_idx;
                        r_state   <= ST_REQ;
                        r_rand_en <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_rand_en <= 1'b0;
                    end
                end
                ST_REQ: begin
                    r_state   <= ST_CAPTURE;
                    r_rand_en <= 1'b0;
                end
                ST_CAPTURE: begin
                    // A zero is the generator's reset value, so ask again.
                    if (is_occupied(rand_type)) begin
                        r_state   <= ST_IDLE;
                        r_rand_en <= 1'b0;
                    end else begin
                        r_state   <= ST_REQ;
                        r_rand_en <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rand_en <= 1'b0;
                end
            endcase
        end
    end

    // Collected report: one-cycle pulse, type held until the next pickup.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_collected_vld  <= 1'b0;
            r_collected_type <= TYPE_NONE;
        end else if (w_pick_hit) begin
            r_collected_vld  <= 1'b1;
            r_collected_type <= w_pick_type;
        end else begin
            r_collected_vld  <= 1'b0;
            r_collected_type <= r_collected_type;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
            collectible_slot #(
                .RESPAWN_TICKS (RESPAWN_TICKS),
                .TIMER_W       (TIMER_W)
            ) u_slot (
                .clk         (clk),
                .reset       (reset),
                .i_load      (w_load[g]),
                .i_load_type (rand_type),
                .i_clear     (w_clear[g]),
                .i_tick      (w_tick_en),
                .o_type      (w_type[g]),
                .o_ready     (w_ready[g])
            );
            assign slot_types[TYPE_W*g +: TYPE_W] = w_type[g];
        end
    endgenerate

    assign rand_en        = r_rand_en;
    assign collected_vld  = r_collected_vld;
    assign collected_type = r_collected_type;

endmodule
